// File: rtl/equiv_check_sequencer_pkg.sv
// Shared state encoding and signature helpers for the equivalence-check sequencer.
package equiv_pkg;
   localparam int SIG_W      = 32;
   localparam int FOLD_MAX_W = 1024;

   typedef enum logic [2:0] {IDLE, FETCH, SETTLE, COMPARE, DONE} state_e;

   // XOR of all 32-bit words; callers zero-extend their vector to FOLD_MAX_W.
   function automatic logic [SIG_W-1:0] fold32(input logic [FOLD_MAX_W-1:0] y);
      logic [SIG_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < FOLD_MAX_W / SIG_W; i++) acc ^= y[i*SIG_W +: SIG_W];
      return acc;
   endfunction
endpackage

// File: rtl/equiv_check_sequencer_if.sv
// Bundle between the vector source, the two DUT instances and the sequencer.
interface equiv_check_sequencer_if
   import equiv_pkg::*;
#(
   parameter int IN_W  = 49,
   parameter int OUT_W = 350,
   parameter int IDX_W = 5
);
   logic             start;
   logic             vec_valid;
   logic [IN_W-1:0]  vec_data;
   logic             vec_ready;
   logic [IN_W-1:0]  dut_in;
   logic [OUT_W-1:0] y_ref;
   logic [OUT_W-1:0] y_dut;
   logic             busy;
   logic             done;
   logic             pass;
   logic [IDX_W-1:0] fail_idx;
   logic [SIG_W-1:0] sig;

   modport master (
      input  start, vec_valid, vec_data, y_ref, y_dut,
      output vec_ready, dut_in, busy, done, pass, fail_idx, sig
   );

   modport slave (
      output start, vec_valid, vec_data, y_ref, y_dut,
      input  vec_ready, dut_in, busy, done, pass, fail_idx, sig
   );
endinterface

// File: rtl/equiv_check_sequencer_sig_misr.sv
// Rotate-left-by-one / XOR response signature register with clear and enable.
module sig_misr
   import equiv_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [SIG_W-1:0] data_i,
   output logic [SIG_W-1:0] sig_o
);
   logic [SIG_W-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr_i)     sig_d = '0;
      else if (en_i) sig_d = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sig_q <= '0;
      else     sig_q <= sig_d;
   end

   assign sig_o = sig_q;
endmodule

// File: rtl/equiv_check_sequencer.sv
// Drives stimulus into reference and synthesised DUTs, waits for settling, compares y and signs it.
module equiv_check_sequencer
   import equiv_pkg::*;
#(
   parameter int IN_W         = 49,
   parameter int OUT_W        = 350,
   parameter int NUM_VEC      = 21,
   parameter int SETTLE_CYC   = 2,
   parameter bit STOP_ON_FAIL = 1'b0,
   parameter int IDX_W        = $clog2(NUM_VEC + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   equiv_check_sequencer_if.master bus
);
   localparam int               CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(NUM_VEC);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VEC - 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IN_W-1:0]  dut_in_q, dut_in_d;
   logic             pass_q, pass_d;
   logic             sig_clr, sig_en;
   logic             mismatch;
   logic [OUT_W-1:0] y_ref, y_dut;
   logic [SIG_W-1:0] y_fold;

   assign y_ref  = bus.y_ref;
   assign y_dut  = bus.y_dut;
   // Case inequality so X/Z on either side counts as a mismatch in simulation.
   assign mismatch = (y_ref !== y_dut);
   assign y_fold   = fold32(FOLD_MAX_W'(y_dut));

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      fail_idx_d = fail_idx_q;
      cnt_d      = cnt_q;
      dut_in_d   = dut_in_q;
      pass_d     = pass_q;
      sig_clr    = 1'b0;
      sig_en     = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d    = FETCH;
               idx_d      = '0;
               fail_idx_d = IDX_NONE;
               pass_d     = 1'b0;
               sig_clr    = 1'b1;
            end
         end
         FETCH: begin
            if (bus.vec_valid) begin
               dut_in_d = bus.vec_data;
               cnt_d    = CNT_INIT;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) state_d = COMPARE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         COMPARE: begin
            sig_en = 1'b1;
            if (mismatch && (fail_idx_q == IDX_NONE)) fail_idx_d = idx_q;
            if ((idx_q == IDX_LAST) || (STOP_ON_FAIL && mismatch)) begin
               state_d = DONE;
               pass_d  = (fail_idx_q == IDX_NONE) && !mismatch;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         fail_idx_q <= IDX_NONE;
         cnt_q      <= '0;
         dut_in_q   <= '0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         fail_idx_q <= fail_idx_d;
         cnt_q      <= cnt_d;
         dut_in_q   <= dut_in_d;
         pass_q     <= pass_d;
      end
   end

   sig_misr u_misr (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (sig_clr),
      .en_i   (sig_en),
      .data_i (y_fold),
      .sig_o  (bus.sig)
   );

   assign bus.vec_ready = (state_q == FETCH);
   assign bus.busy      = (state_q == FETCH) || (state_q == SETTLE) || (state_q == COMPARE);
   assign bus.done      = (state_q == DONE);
   assign bus.pass      = pass_q;
   assign bus.fail_idx  = fail_idx_q;
   assign bus.dut_in    = dut_in_q;
endmodule

// File: tb/tb_equiv_check_sequencer.sv
// Scoreboard bench: two sequencers (settle 2 / run-all, settle 4 / stop-on-fail) fed by modelled DUT pipelines.
module tb_equiv_check_sequencer;
   import equiv_pkg::*;

   localparam int IN_W  = 49;
   localparam int OUT_W = 350;
   localparam int NV    = 3;
   localparam int IDX_W = $clog2(NV + 1);
   localparam logic [IN_W-1:0] FL = 49'h1_0000_0000_0000;

   typedef struct {
      bit          pass;
      int          fidx;
      logic [31:0] sig;
      int          nhs;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   tests = 0, fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   equiv_check_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) ia ();
   equiv_check_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) ib ();

   equiv_check_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(NV), .SETTLE_CYC(2),
                           .STOP_ON_FAIL(1'b0), .IDX_W(IDX_W))
      u_a (.clk(clk), .rst(rst), .bus(ia));
   equiv_check_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(NV), .SETTLE_CYC(4),
                           .STOP_ON_FAIL(1'b1), .IDX_W(IDX_W))
      u_b (.clk(clk), .rst(rst), .bus(ib));

   // DUT model: latency equals SETTLE_CYC; bit 48 of the vector flips y_dut[349] only.
   logic [IN_W-1:0] pa [2];
   logic [IN_W-1:0] pb [4];
   always @(posedge clk) begin
      pa[0] <= ia.dut_in;
      pa[1] <= pa[0];
      pb[0] <= ib.dut_in;
      for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
   end
   assign ia.y_ref = {302'b0, pa[1][47:0]};
   assign ia.y_dut = {pa[1][48], 301'b0, pa[1][47:0]};
   assign ib.y_ref = {302'b0, pb[3][47:0]};
   assign ib.y_dut = {pb[3][48], 301'b0, pb[3][47:0]};

   exp_t            qa[$], qb[$];
   logic [IN_W-1:0] fa[$], fb[$];
   bit              hold_a = 1'b0;
   int              hs_a = 0, hs_b = 0, hcyc_a = 0, hcyc_b = 0, base_a = 0, base_b = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input bit p, input int f, input logic [31:0] s, input int n, input int l);
      exp_t e;
      e.pass = p; e.fidx = f; e.sig = s; e.nhs = n; e.lat = l;
      return e;
   endfunction

   // Feeders: valid/data change on negedge; a handshake is committed when ready is seen before the edge.
   initial begin
      ia.vec_valid = 1'b0;
      ia.vec_data  = '0;
      forever begin
         @(negedge clk);
         if (fa.size() > 0 && !hold_a) begin ia.vec_valid = 1'b1; ia.vec_data = fa[0]; end
         else ia.vec_valid = 1'b0;
         if (ia.vec_valid && ia.vec_ready && !rst) begin
            void'(fa.pop_front());
            hs_a++;
            hcyc_a = cyc + 1;
         end
      end
   end

   initial begin
      ib.vec_valid = 1'b0;
      ib.vec_data  = '0;
      forever begin
         @(negedge clk);
         if (fb.size() > 0) begin ib.vec_valid = 1'b1; ib.vec_data = fb[0]; end
         else ib.vec_valid = 1'b0;
         if (ib.vec_valid && ib.vec_ready && !rst) begin
            void'(fb.pop_front());
            hs_b++;
            hcyc_b = cyc + 1;
         end
      end
   end

   // Monitors: compare on each rising done.
   initial begin
      bit   dprev;
      exp_t e;
      dprev = 1'b0;
      forever begin
         @(negedge clk);
         if (ia.done && !dprev) begin
            if (qa.size() == 0) begin
               tests++; fails++;
               $display("FAIL a_unexpected_done: done=1, required no result");
            end else begin
               e = qa.pop_front();
               chk("a_pass", ia.pass, e.pass);
               chk("a_fail_idx", ia.fail_idx, e.fidx);
               chk("a_sig", ia.sig, e.sig);
               chk("a_vectors", hs_a - base_a, e.nhs);
               chk("a_latency", cyc - hcyc_a, e.lat);
            end
         end
         dprev = ia.done;
      end
   end

   initial begin
      bit   dprev;
      exp_t e;
      dprev = 1'b0;
      forever begin
         @(negedge clk);
         if (ib.done && !dprev) begin
            if (qb.size() == 0) begin
               tests++; fails++;
               $display("FAIL b_unexpected_done: done=1, required no result");
            end else begin
               e = qb.pop_front();
               chk("b_pass", ib.pass, e.pass);
               chk("b_fail_idx", ib.fail_idx, e.fidx);
               chk("b_sig", ib.sig, e.sig);
               chk("b_vectors", hs_b - base_b, e.nhs);
               chk("b_latency", cyc - hcyc_b, e.lat);
            end
         end
         dprev = ib.done;
      end
   end

   task automatic pulse_start(input bit b);
      @(negedge clk);
      if (b) ib.start = 1'b1; else ia.start = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
      ib.start = 1'b0;
   endtask

   task automatic wait_empty(input bit b, input string nm);
      int n = 0;
      while ((b ? qb.size() : qa.size()) > 0 && n < 300) begin @(negedge clk); n++; end
      if ((b ? qb.size() : qa.size()) > 0) begin
         tests++; fails++;
         $display("FAIL %s: no done within %0d cycles", nm, n);
         qa.delete(); qb.delete();
      end
      fa.delete(); fb.delete();
      @(negedge clk);
   endtask

   task automatic wait_hs(input bit b, input int n, input string nm);
      int k = 0;
      while (((b ? hs_b - base_b : hs_a - base_a) < n) && k < 100) begin @(negedge clk); k++; end
      if ((b ? hs_b - base_b : hs_a - base_a) < n) begin
         tests++; fails++;
         $display("FAIL %s: handshake %0d not seen within %0d cycles", nm, n, k);
      end
   endtask

   task automatic run(input bit b, input string nm, input logic [IN_W-1:0] v0, v1, v2, input exp_t e);
      if (b) begin base_b = hs_b; fb = '{v0, v1, v2}; qb.push_back(e); end
      else   begin base_a = hs_a; fa = '{v0, v1, v2}; qa.push_back(e); end
      pulse_start(b);
      wait_empty(b, nm);
   endtask

   task automatic chk_reset_a(input string pfx);
      chk({pfx, "_dut_in"}, ia.dut_in, 0);
      chk({pfx, "_vec_ready"}, ia.vec_ready, 0);
      chk({pfx, "_busy"}, ia.busy, 0);
      chk({pfx, "_done"}, ia.done, 0);
      chk({pfx, "_pass"}, ia.pass, 0);
      chk({pfx, "_fail_idx"}, ia.fail_idx, NV);
      chk({pfx, "_sig"}, ia.sig, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      ia.start = 1'b0;
      ib.start = 1'b0;
      rst = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_a("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Clean, single mismatch, multiple mismatches (first one kept).
      run(1'b0, "a_clean",    49'h1, 49'h1, 49'h1, mk(1'b1, 3, 32'h0000_0007, 3, 3));
      run(1'b0, "a_mismatch", 49'h1, FL | 49'h1, 49'h1, mk(1'b0, 1, 32'h4000_0007, 3, 3));
      run(1'b0, "a_multi",    FL, 49'h0, FL, mk(1'b0, 0, 32'hA000_0000, 3, 3));

      // Backpressure in FETCH, then a start pulse while busy.
      hold_a = 1'b1;
      base_a = hs_a;
      fa = '{49'h0_ABCD_0000_0001, 49'h2, 49'h4};
      qa.push_back(mk(1'b1, 3, 32'h0002_AF30, 3, 3));
      pulse_start(1'b0);
      repeat (5) begin
         @(negedge clk);
         chk("bp_vec_ready", ia.vec_ready, 1);
         chk("bp_dut_in", ia.dut_in, FL);
         chk("bp_busy", ia.busy, 1);
      end
      chk("bp_no_handshake", hs_a - base_a, 0);
      chk("bp_no_compare_sig", ia.sig, 0);
      hold_a = 1'b0;
      wait_hs(1'b0, 2, "bp_resume");
      pulse_start(1'b0);
      chk("start_while_busy", ia.busy, 1);
      wait_empty(1'b0, "a_backpressure");

      // Asynchronous reset in the middle of SETTLE.
      base_a = hs_a;
      fa = '{FL | 49'h9, 49'h6};
      pulse_start(1'b0);
      wait_hs(1'b0, 2, "abort_hs");
      @(negedge clk);
      chk("pre_rst_sig", ia.sig, 32'h2000_0009);
      chk("pre_rst_fail_idx", ia.fail_idx, 0);
      chk("pre_rst_dut_in", ia.dut_in, 6);
      #2 rst = 1'b1;
      #1 chk_reset_a("abort");
      fa.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_idle_busy", ia.busy, 0);
      chk("post_rst_idle_ready", ia.vec_ready, 0);

      // Stop on first failure, then a clean run restarted from DONE; settle of 4 cycles.
      run(1'b1, "b_stop",  FL | 49'h5, 49'h7, 49'h7, mk(1'b0, 0, 32'h2000_0005, 1, 5));
      run(1'b1, "b_clean", 49'h3, 49'h5, 49'h7, mk(1'b1, 3, 32'h0000_0001, 3, 5));

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
